// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared TMDS constants: control tokens and disparity counter width
package hdmi_pkg;

    localparam int CNT_W_DEF = 5;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
        logic [9:0] tok;
        case ({c1, c0})
            2'b00:   tok = CTRL_TOKEN_00;
            2'b01:   tok = CTRL_TOKEN_01;
            2'b10:   tok = CTRL_TOKEN_10;
            default: tok = CTRL_TOKEN_11;
        endcase
        return tok;
    endfunction

endpackage

// File: rtl/popcnt8.sv
// rtl/popcnt8.sv - combinational population count of an 8-bit word
module popcnt8 (
    input  logic [7:0] data_i,
    output logic [3:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < 8; i++) begin
            count_o = count_o + {3'b000, data_i[i]};
        end
    end

endmodule

// File: rtl/tmds_encode.sv
// rtl/tmds_encode.sv - three-stage TMDS 8b/10b encoder for one colour channel
module tmds_encode
    import hdmi_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] data_in,
    input  logic       c0,
    input  logic       c1,
    input  logic       de,
    output logic [9:0] data_out
);

    logic [7:0] d1_q;
    logic       de1_q, c0_1_q, c1_1_q;
    logic [3:0] n1d_d, n1d_q;

    logic [8:0] qm_d, qm_q;
    logic [3:0] n1q_d, n1q_q, n0q_q;
    logic       de2_q, c0_2_q, c1_2_q;
    logic       use_xnor;

    logic signed [CNT_W-1:0] cnt_d, cnt_q;
    logic signed [CNT_W-1:0] diff, two_qm8, two_nqm8;
    logic [9:0]              dout_d;

    popcnt8 u_popcnt_d (.data_i(data_in),    .count_o(n1d_d));
    popcnt8 u_popcnt_q (.data_i(qm_d[7:0]), .count_o(n1q_d));

    // XNOR chain flips every link, so it is the XOR chain with use_xnor folded in
    always_comb begin
        use_xnor = (n1d_q > 4'd4) || ((n1d_q == 4'd4) && !d1_q[0]);
        qm_d     = '0;
        qm_d[0]  = d1_q[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = qm_d[i-1] ^ d1_q[i] ^ use_xnor;
        end
        qm_d[8] = ~use_xnor;
    end

    assign diff     = $signed({{(CNT_W-4){1'b0}}, n1q_q}) - $signed({{(CNT_W-4){1'b0}}, n0q_q});
    assign two_qm8  = qm_q[8] ? CNT_W'(2) : '0;
    assign two_nqm8 = qm_q[8] ? '0 : CNT_W'(2);

    // cnt is nonzero in the second data branch, so a clear sign bit means cnt > 0
    always_comb begin
        dout_d = ctrl_token(c1_2_q, c0_2_q);
        cnt_d  = '0;
        if (de2_q) begin
            if ((cnt_q == '0) || (n1q_q == n0q_q)) begin
                dout_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                cnt_d  = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
            end else if ((!cnt_q[CNT_W-1] && (n1q_q > n0q_q)) ||
                         ( cnt_q[CNT_W-1] && (n0q_q > n1q_q))) begin
                dout_d = {1'b1, qm_q[8], ~qm_q[7:0]};
                cnt_d  = cnt_q + two_qm8 - diff;
            end else begin
                dout_d = {1'b0, qm_q[8], qm_q[7:0]};
                cnt_d  = cnt_q - two_nqm8 + diff;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            d1_q     <= '0;
            de1_q    <= 1'b0;
            c0_1_q   <= 1'b0;
            c1_1_q   <= 1'b0;
            n1d_q    <= '0;
            qm_q     <= '0;
            n1q_q    <= '0;
            n0q_q    <= '0;
            de2_q    <= 1'b0;
            c0_2_q   <= 1'b0;
            c1_2_q   <= 1'b0;
            cnt_q    <= '0;
            data_out <= '0;
        end else begin
            d1_q     <= data_in;
            de1_q    <= de;
            c0_1_q   <= c0;
            c1_1_q   <= c1;
            n1d_q    <= n1d_d;
            qm_q     <= qm_d;
            n1q_q    <= n1q_d;
            n0q_q    <= 4'd8 - n1q_d;
            de2_q    <= de1_q;
            c0_2_q   <= c0_1_q;
            c1_2_q   <= c1_1_q;
            cnt_q    <= cnt_d;
            data_out <= dout_d;
        end
    end

endmodule
